// File: rtl/alu_pkg.sv
// Shared ALU constants and the sequential left-shifter state type.
// ALU bit order: ALU index i maps to vector bit (WIDTH-1-i), so ALU index 0 is the MSB.
package alu_pkg;

    localparam int ALU_WIDTH = 20;
    localparam int ALU_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shftl_state_t;

endpackage

// File: rtl/shftl_step.sv
// Combinational single-position left shift/rotate toward ALU index 0 (the MSB).
// The bit leaving ALU index 0 is reported on carry_out.
module shftl_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             rot,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    // On a rotate, the outgoing MSB re-enters at ALU index WIDTH-1 (the LSB).
    assign carry_out = in[WIDTH-1];
    assign out       = {in[WIDTH-2:0], rot & in[WIDTH-1]};

endmodule

// File: rtl/shftl_seq.sv
// Multi-cycle left shifter: one position per clock, start/busy/done handshake, carry/zero flags.
// Define SHFTL_ROTATE_EN to add the rot input, which selects rotate instead of shift.
module shftl_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amt,
`ifdef SHFTL_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    shftl_state_t     state;
    shftl_state_t     state_next;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_cnt;
    logic             accept;
    logic             rot_q;
    logic [WIDTH-1:0] step_out;
    logic             step_carry;

    // Amounts beyond the datapath width behave exactly like a full-width shift.
    assign load_cnt = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;
    assign accept   = start && (state != SHIFT);

    shftl_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .in       (sreg),
        .rot      (rot_q),
        .out      (step_out),
        .carry_out(step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assign a default before the case so every path drives state_next; otherwise a latch is inferred.
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (load_cnt == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath: capture on an accepted start, step while shifting, otherwise hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is written with <= so all registers update from pre-edge values.
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sreg  <= a;
            carry <= 1'b0;
            cnt   <= load_cnt;
        end else if (state == SHIFT) begin
            sreg  <= step_out;
            carry <= step_carry;
            cnt   <= cnt - CNT_W'(1);
        end
    end

`ifdef SHFTL_ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= rot;
        end
    end
`else
    assign rot_q = 1'b0;
`endif

    assign out  = sreg;
    assign zero = (sreg == '0);

endmodule

// File: tb/tb_shftl_seq.sv
// Self-checking bench for shftl_seq: directed plan cases, back-to-back, ignored start,
// reset mid-shift and randomized operations against an arithmetic reference model.
module tb_shftl_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rot;
    logic [19:0] a;
    logic [4:0]  amt;
    logic        busy;
    logic        done;
    logic [19:0] out;
    logic        carry;
    logic        zero;

    int errors = 0;
    int checks = 0;

`ifdef SHFTL_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    shftl_seq dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .amt  (amt),
`ifdef SHFTL_ROTATE_EN
        .rot  (rot),
`endif
        .busy (busy),
        .done (done),
        .out  (out),
        .carry(carry),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift/rotate by the clamped amount in one arithmetic step.
    function automatic void model(input logic [19:0] av, input logic [4:0] amv, input bit rv,
                                  output logic [19:0] o, output logic c, output int n);
        logic [39:0] w;
        n = (amv > 5'd20) ? 20 : int'(amv);
        if (n == 0) begin
            o = av;
            c = 1'b0;
        end else begin
            w = {20'b0, av} << n;
            o = w[19:0] | (rv ? w[39:20] : 20'b0);
            c = av[20-n];
        end
    endfunction

    task automatic start_op(input logic [19:0] av, input logic [4:0] amv, input bit rv);
        start = 1'b1;
        a     = av;
        amt   = amv;
        rot   = rv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int lat, output int bc);
        int k = k0;
        bc = 0;
        while (done !== 1'b1 && k <= 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
        lat = k;
    endtask

    task automatic test_op(input string name, input logic [19:0] av, input logic [4:0] amv, input bit rv);
        logic [19:0] exp_o;
        logic        exp_c;
        int          n, lat, bc;
        model(av, amv, rv, exp_o, exp_c, n);
        start_op(av, amv, rv);
        wait_done(1, lat, bc);
        checks++; if (lat !== n + 1) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, n + 1); end
        checks++; if (bc !== n) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, n); end
        checks++; if (out !== exp_o) begin errors++; $display("FAIL %s out: got %h expected %h", name, out, exp_o); end
        checks++; if (carry !== exp_c) begin errors++; $display("FAIL %s carry: got %b expected %b", name, carry, exp_c); end
        checks++; if (zero !== (exp_o == 20'h0)) begin errors++; $display("FAIL %s zero: got %b expected %b", name, zero, exp_o == 20'h0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got %b expected 0", name, done); end
        checks++; if (out !== exp_o || carry !== exp_c) begin errors++; $display("FAIL %s hold: got %h/%b expected %h/%b", name, out, carry, exp_o, exp_c); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        amt   = '0;
        rot   = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out !== 20'h0) begin errors++; $display("FAIL reset out: got %h expected 00000", out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset carry: got %b expected 0", carry); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset zero: got %b expected 1", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        bit seen = 1'b0;
        start_op(20'h00001, 5'd10, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 20'h0) begin errors++; $display("FAIL midrst out: got %h expected 00000", out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL midrst carry: got %b expected 0", carry); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL midrst zero: got %b expected 1", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
        repeat (2) begin @(negedge clk); seen |= done; end
        rst_n = 1'b1;
        repeat (15) begin @(negedge clk); seen |= done; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst no_done: got %b expected 0", seen); end
    endtask

    task automatic test_directed();
        test_op("plan_amt3", 20'h00001, 5'd3, 1'b0);
        test_op("plan_c0000", 20'hC0000, 5'd2, 1'b0);
        test_op("plan_amt0", 20'h12345, 5'd0, 1'b0);
        test_op("plan_amt25", 20'h00001, 5'd25, 1'b0);
        test_op("amt1", 20'h80001, 5'd1, 1'b0);
        test_op("amt20", 20'hABCDE, 5'd20, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [19:0] av, exp_o;
        logic        exp_c;
        int          n, lat, bc;
        av = 20'($urandom);
        model(av, 5'd3, 1'b0, exp_o, exp_c, n);
        start_op(av, 5'd3, 1'b0);
        wait_done(1, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b first_latency: got %0d expected 4", lat); end
        checks++; if (out !== exp_o) begin errors++; $display("FAIL b2b first_out: got %h expected %h", out, exp_o); end
        start_op(20'h00002, 5'd1, 1'b0);
        wait_done(1, lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b second_latency: got %0d expected 2", lat); end
        checks++; if (out !== 20'h00004) begin errors++; $display("FAIL b2b second_out: got %h expected 00004", out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL b2b second_carry: got %b expected 0", carry); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        logic [19:0] exp_o;
        logic        exp_c;
        int          n, lat, bc;
        model(20'h00F0F, 5'd6, 1'b0, exp_o, exp_c, n);
        start_op(20'h00F0F, 5'd6, 1'b0);
        start_op(20'hFFFFF, 5'd0, 1'b0);
        wait_done(2, lat, bc);
        checks++; if (lat !== 7) begin errors++; $display("FAIL ignored latency: got %0d expected 7", lat); end
        checks++; if (out !== exp_o) begin errors++; $display("FAIL ignored out: got %h expected %h", out, exp_o); end
        checks++; if (carry !== exp_c) begin errors++; $display("FAIL ignored carry: got %b expected %b", carry, exp_c); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignored idle: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            test_op("random", 20'($urandom), 5'($urandom_range(0, 31)), ROT_EN && ($urandom_range(0, 1) == 1));
        end
    endtask

`ifdef SHFTL_ROTATE_EN
    task automatic test_rotate();
        test_op("rot1", 20'h80001, 5'd1, 1'b1);
        test_op("rot0", 20'h80001, 5'd1, 1'b0);
        test_op("rot20", 20'h5A5A3, 5'd20, 1'b1);
        test_op("rot31", 20'h00F01, 5'd31, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_directed();
        test_back_to_back();
        test_ignored_start();
`ifdef SHFTL_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
